// File: rtl/stream_delay_pkg.sv
`default_nettype none
// ============================================================================
// Package : stream_delay_pkg
// Shared rate-limiter configuration and token-count width helper.
// Rev     : 1.0
// ============================================================================
package stream_delay_pkg;

  typedef struct packed {
    int unsigned period;
    int unsigned tokens;
    int unsigned max_tokens;
  } rate_cfg_t;

  localparam rate_cfg_t DEFAULT_RATE_CFG = '{period: 16, tokens: 4, max_tokens: 8};

  // Bits needed to hold a token count in 0..max_tokens inclusive.
  function automatic int tok_width(input int max_tokens);
    return $clog2(max_tokens + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_rate_limiter.sv
`default_nettype none
// ============================================================================
// Module : stream_rate_limiter
// Token-bucket rate limiter gating a zero-latency valid/ready stream.
// Rev    : 1.0
// ============================================================================
module stream_rate_limiter
  import stream_delay_pkg::*;
#(
  parameter type payload_t = logic,
  parameter int  Period    = 16,
  parameter int  Tokens    = 4,
  parameter int  MaxTokens = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  payload_t                       payload_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output payload_t                       payload_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [tok_width(MaxTokens)-1:0] tokens_o,
  output logic                           stall_o
);

  localparam int TOK_W = tok_width(MaxTokens);
  localparam int SUM_W = $clog2(MaxTokens + Tokens + 1);
  localparam int CNT_W = (Period > 1) ? $clog2(Period) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Period - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SUM_W-1:0] SUM_TOK  = SUM_W'(Tokens);
  localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'(MaxTokens);
  localparam logic [TOK_W-1:0] TOK_MAX  = TOK_W'(MaxTokens);

  if (Period < 1) begin : g_chk_period
    $fatal(1, "stream_rate_limiter: Period must be at least 1");
  end
  if (Tokens < 1) begin : g_chk_tokens
    $fatal(1, "stream_rate_limiter: Tokens must be at least 1");
  end
  if (MaxTokens < Tokens) begin : g_chk_max
    $fatal(1, "stream_rate_limiter: MaxTokens must be at least Tokens");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOK_W-1:0] tokens_q, tokens_d;
  logic [SUM_W-1:0] sum;
  logic             pass;
  logic             refill;
  logic             consume;

  always_comb begin
    pass     = ~rst_i & (~en_i | (tokens_q != '0));
    refill   = (cnt_q == CNT_LAST);
    consume  = valid_i & ready_i & pass & en_i;
    cnt_d    = refill ? '0 : cnt_q + CNT_ONE;
    // Consume and refill combine before saturation, so a full bucket stays full.
    sum      = SUM_W'(tokens_q) - SUM_W'(consume) + (refill ? SUM_TOK : '0);
    tokens_d = (sum > SUM_MAX) ? TOK_MAX : sum[TOK_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      tokens_q <= TOK_MAX;
    end else begin
      cnt_q    <= cnt_d;
      tokens_q <= tokens_d;
    end
  end

  assign payload_o = payload_i;
  assign valid_o   = valid_i & pass;
  assign ready_o   = ready_i & pass;
  assign tokens_o  = tokens_q;
  assign stall_o   = ~rst_i & en_i & valid_i & ready_i & (tokens_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_stream_rate_limiter.sv
`default_nettype none
// ============================================================================
// Module : tb_stream_rate_limiter
// Directed and randomized checks of the token-bucket limiter against a model.
// Rev    : 1.0
// ============================================================================
module tb_stream_rate_limiter;
  import stream_delay_pkg::*;

  localparam int P = 16;
  localparam int T = 4;
  localparam int M = 8;

  typedef logic [7:0] pl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, valid, ready;
  pl_t  pin, pout;
  logic vo, ro, st;
  logic [tok_width(M)-1:0] tok;

  logic rst2, en2, v2, r2, p2i, p2o, vo2, ro2, st2;
  logic [tok_width(1)-1:0] tok2;

  stream_rate_limiter #(
    .payload_t(pl_t), .Period(P), .Tokens(T), .MaxTokens(M)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .payload_i(pin), .valid_i(valid),
    .ready_o(ro), .payload_o(pout), .valid_o(vo), .ready_i(ready),
    .tokens_o(tok), .stall_o(st)
  );

  stream_rate_limiter #(
    .Period(1), .Tokens(1), .MaxTokens(1)
  ) dut2 (
    .clk_i(clk), .rst_i(rst2), .en_i(en2), .payload_i(p2i), .valid_i(v2),
    .ready_o(ro2), .payload_o(p2o), .valid_o(vo2), .ready_i(r2),
    .tokens_o(tok2), .stall_o(st2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_tok   = 0;
  int m_phase = 0;
  bit m_known = 1'b0;
  int xfers   = 0;
  logic last_valid, last_ready, last_stall, last_vo2, last_ro2, last_st2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the reference, then step.
  task automatic step();
    bit pass, xfer;
    @(negedge clk);
    pass = !rst && (!en || m_tok > 0);
    chk("valid_o", 32'(vo), 32'(valid && pass));
    chk("ready_o", 32'(ro), 32'(ready && pass));
    chk("stall_o", 32'(st), 32'(!rst && valid && ready && en && m_tok == 0));
    chk("payload_o", 32'(pout), 32'(pin));
    if (m_known) chk("tokens_o", 32'(tok), 32'(m_tok));
    last_valid = vo; last_ready = ro; last_stall = st;
    last_vo2 = vo2; last_ro2 = ro2; last_st2 = st2;
    if (vo && ready) xfers++;
    if (rst) begin
      m_tok = M; m_phase = 0; m_known = 1'b1;
    end else begin
      xfer  = valid && ready && pass;
      m_tok = m_tok - ((xfer && en) ? 1 : 0) + ((m_phase == P - 1) ? T : 0);
      if (m_tok > M) m_tok = M;
      m_phase = (m_phase + 1) % P;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; ready = 1'b0; pin = '0;
    rst2 = 1'b1; en2 = 1'b1; v2 = 1'b1; r2 = 1'b1; p2i = 1'b0;
    step(); step();
    rst = 1'b0; rst2 = 1'b0;
    chk("reset_tokens", 32'(tok), 32'(M));

    // Burst from full.
    valid = 1'b1; ready = 1'b1; xfers = 0;
    for (int c = 0; c < 48; c++) begin
      pin = pl_t'($urandom);
      step();
      if (c == 7) chk("burst_first8", 32'(xfers), 32'd8);
      if (c == 8) chk("burst_stall8", 32'(last_stall), 32'd1);
    end
    chk("burst_total48", 32'(xfers), 32'd16);

    // Consume in the refill cycle of a full bucket.
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b0;
    for (int c = 0; c < 15; c++) step();
    en = 1'b1;
    step();
    chk("sat_tokens", 32'(tok), 32'(M));

    // Limiting disabled: transparent pass-through.
    en = 1'b0; xfers = 0;
    for (int c = 0; c < 100; c++) begin
      pin = pl_t'($urandom);
      step();
    end
    chk("bypass_xfers", 32'(xfers), 32'd100);
    chk("bypass_tokens", 32'(tok), 32'(M));

    // Downstream backpressure.
    en = 1'b1; ready = 1'b0; xfers = 0;
    for (int c = 0; c < 40; c++) step();
    chk("bp_xfers", 32'(xfers), 32'd0);
    chk("bp_tokens", 32'(tok), 32'(M));
    chk("bp_stall", 32'(last_stall), 32'd0);
    chk("bp_ready", 32'(last_ready), 32'd0);

    // Reset in the middle of a burst.
    rst = 1'b1; step(); rst = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("mid_tokens2", 32'(tok), 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_valid_rst", 32'(last_valid), 32'd0);
    chk("mid_tokens_after", 32'(tok), 32'(M));
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 14) chk("mid_pre_refill", 32'(tok), 32'd0);
      if (c == 15) chk("mid_refill", 32'(tok), 32'(T));
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      en    = ($urandom_range(0, 3) != 0);
      valid = $urandom_range(0, 1) == 1;
      ready = $urandom_range(0, 3) != 0;
      pin   = pl_t'($urandom);
      step();
    end
    rst = 1'b0;

    // Period=1, Tokens=1, MaxTokens=1: one transfer every cycle.
    valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      p2i = c[0];
      step();
      chk("p1_valid", 32'(last_vo2), 32'd1);
      chk("p1_ready", 32'(last_ro2), 32'd1);
      chk("p1_stall", 32'(last_st2), 32'd0);
      chk("p1_tokens", 32'(tok2), 32'd1);
    end
    chk("p1_payload", 32'(p2o), 32'(p2i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
